// File: rtl/mobo_mem_resp.sv
// Wait-stated word memory answering a four-phase req/done handshake.
// Out-of-range addresses raise err and never touch the array.
module mobo_mem_resp #(
  parameter int WORD_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_WIDTH-1:0] mobo_ctrl,
  input  logic [WORD_WIDTH-1:0] mobo_addr,
  input  logic [WORD_WIDTH-1:0] mobo_wdata,
  output logic [WORD_WIDTH-1:0] mobo_rdata,
  output logic [WORD_WIDTH-1:0] mobo_stat
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WLAST =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [WORD_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  logic          req;
  logic          we_in;
  logic          in_range;
  logic          mem_we;
  logic [AW-1:0] idx;
  logic          unused_ctrl;

  assign req         = mobo_ctrl[0];
  assign we_in       = mobo_ctrl[1];
  assign unused_ctrl = ^mobo_ctrl[WORD_WIDTH-1:2];
  assign idx         = addr_q[AW-1:0];
  assign in_range    = addr_q < WORD_WIDTH'(DEPTH);
  assign mem_we      = (state_q == S_ACCESS) && we_q && in_range;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we_in;
          addr_d  = mobo_addr;
          wdata_d = mobo_wdata;
          busy_d  = 1'b1;
          cnt_d   = 4'd0;
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (cnt_q == WLAST) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ACCESS: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        err_d   = !in_range;
        cnt_d   = 4'd0;
        state_d = S_DONE;
        // A write keeps the last read data on the bus.
        if (!we_q) begin
          rdata_d = in_range ? mem[idx] : '0;
        end
      end
      S_DONE: begin
        if (!req) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Array is left out of reset; reset forces IDLE so no write can land.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= wdata_q;
    end
  end

  assign mobo_rdata = rdata_q;
  assign mobo_stat  = {{(WORD_WIDTH-3){1'b0}}, err_q, done_q, busy_q};

endmodule

// File: tb/tb_mobo_mem_resp.sv
// Bench for mobo_mem_resp: vector table, random traffic vs. array model,
// plus latch, zero-wait and mid-transaction reset sequences.
module tb_mobo_mem_resp;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n [2];
  logic [W-1:0] ctrl  [2];
  logic [W-1:0] addr  [2];
  logic [W-1:0] wdata [2];
  logic [W-1:0] rdata [2];
  logic [W-1:0] stat  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mobo_mem_resp #(.WORD_WIDTH(W), .DEPTH(256), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .mobo_ctrl(ctrl[0]),
    .mobo_addr(addr[0]), .mobo_wdata(wdata[0]),
    .mobo_rdata(rdata[0]), .mobo_stat(stat[0])
  );

  mobo_mem_resp #(.WORD_WIDTH(W), .DEPTH(256), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .mobo_ctrl(ctrl[1]),
    .mobo_addr(addr[1]), .mobo_wdata(wdata[1]),
    .mobo_rdata(rdata[1]), .mobo_stat(stat[1])
  );

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (stat[d][0] === 1'b1 && stat[d][1] === 1'b1) begin
        errors++;
        $display("FAIL busy_done_overlap dut%0d: stat %h expected not both",
                 d, stat[d]);
      end
    end
  end

  task automatic txn(input int d, input bit we, input logic [W-1:0] a,
                     input logic [W-1:0] wd, input bit scramble,
                     output int lat, output logic [W-1:0] rd,
                     output logic [W-1:0] st);
    @(negedge clk);
    ctrl[d]  = {30'b0, we, 1'b1};
    addr[d]  = a;
    wdata[d] = wd;
    lat = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (scramble && lat == 1) begin
        addr[d]    = a + 1;
        wdata[d]   = ~wd;
        ctrl[d][1] = ~we;
      end
      if (stat[d][1] === 1'b1 || lat >= 40) break;
    end
    chk("done_seen", W'(stat[d][1]), 1);
    rd = rdata[d];
    st = stat[d];
    @(posedge clk);
    #1;
    chk("hold_stat", stat[d], st);
    chk("hold_rdata", rdata[d], rd);
    @(negedge clk);
    ctrl[d] = '0;
    @(posedge clk);
    #1;
    chk("done_clear", stat[d], 0);
    chk("rdata_keep", rdata[d], rd);
  endtask

  typedef struct {
    bit           we;
    logic [W-1:0] a;
    logic [W-1:0] wd;
    logic [W-1:0] st;
    bit           ck_rd;
    logic [W-1:0] rd;
  } vec_t;

  vec_t         tbl [11];
  logic [W-1:0] mdl [256];
  bit           known [256];

  initial begin
    int           lat;
    logic [W-1:0] rd, st, last_rd, exp_rd;
    bit           last_known;

    tbl[0]  = '{1'b1, 32'd5,   32'hDEADBEEF, 32'h2, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'd5,   32'h0,        32'h2, 1'b1, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'd44,  32'h12345678, 32'h2, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 32'd300, 32'hCAFEF00D, 32'h6, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 32'd44,  32'h0,        32'h2, 1'b1, 32'h12345678};
    tbl[5]  = '{1'b0, 32'd300, 32'h0,        32'h6, 1'b1, 32'h0};
    tbl[6]  = '{1'b1, 32'd255, 32'hA5A5A5A5, 32'h2, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 32'd255, 32'h0,        32'h2, 1'b1, 32'hA5A5A5A5};
    tbl[8]  = '{1'b1, 32'd256, 32'h0BADF00D, 32'h6, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 32'h80000005, 32'h0,   32'h6, 1'b1, 32'h0};
    tbl[10] = '{1'b0, 32'd5,   32'h0,        32'h2, 1'b1, 32'hDEADBEEF};

    for (int i = 0; i < 256; i++) known[i] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      ctrl[d]  = '0;
      addr[d]  = '0;
      wdata[d] = '0;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_stat0", stat[0], 0);
    chk("rst_rdata0", rdata[0], 0);
    chk("rst_stat1", stat[1], 0);
    chk("rst_rdata1", rdata[1], 0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    for (int i = 0; i < 11; i++) begin
      txn(0, tbl[i].we, tbl[i].a, tbl[i].wd, 1'b0, lat, rd, st);
      chk($sformatf("tbl%0d_lat", i), W'(lat), 4);
      chk($sformatf("tbl%0d_stat", i), st, tbl[i].st);
      if (tbl[i].ck_rd) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
      if (tbl[i].we && tbl[i].a < 256) begin
        mdl[tbl[i].a[7:0]]   = tbl[i].wd;
        known[tbl[i].a[7:0]] = 1'b1;
      end
    end

    last_rd    = 32'hDEADBEEF;
    last_known = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bit           we, oor;
      logic [W-1:0] a, wd;
      int           sel;
      we  = bit'($urandom % 2);
      sel = int'($urandom % 4);
      case (sel)
        0:       a = W'($urandom % 8);
        1:       a = W'(248 + $urandom % 8);
        2:       a = W'(256 + $urandom % 64);
        default: a = W'($urandom);
      endcase
      wd  = W'($urandom);
      oor = (a >= 256);
      txn(0, we, a, wd, 1'b0, lat, rd, st);
      chk($sformatf("rnd%0d_lat", i), W'(lat), 4);
      chk($sformatf("rnd%0d_stat", i), st, oor ? 32'h6 : 32'h2);
      if (we) begin
        if (!oor) begin
          if (last_known) chk($sformatf("rnd%0d_wr_rdata", i), rd, last_rd);
          mdl[a[7:0]]   = wd;
          known[a[7:0]] = 1'b1;
        end else begin
          last_known = 1'b0;
        end
      end else begin
        if (oor || known[a[7:0]]) begin
          exp_rd = oor ? '0 : mdl[a[7:0]];
          chk($sformatf("rnd%0d_rdata", i), rd, exp_rd);
          last_rd    = exp_rd;
          last_known = 1'b1;
        end else begin
          last_known = 1'b0;
        end
      end
    end

    txn(0, 1'b1, 32'd10, 32'h77, 1'b0, lat, rd, st);
    txn(0, 1'b1, 32'd9, 32'h11, 1'b1, lat, rd, st);
    chk("latch_stat", st, 32'h2);
    txn(0, 1'b0, 32'd9, 32'h0, 1'b0, lat, rd, st);
    chk("latch_rd9", rd, 32'h11);
    txn(0, 1'b0, 32'd10, 32'h0, 1'b0, lat, rd, st);
    chk("latch_rd10", rd, 32'h77);

    txn(1, 1'b1, 32'd0, 32'h5A5A, 1'b0, lat, rd, st);
    chk("w0_wr_lat", W'(lat), 2);
    txn(1, 1'b0, 32'd0, 32'h0, 1'b0, lat, rd, st);
    chk("w0_rd_lat", W'(lat), 2);
    chk("w0_rd_data", rd, 32'h5A5A);
    chk("w0_rd_stat", st, 32'h2);

    txn(0, 1'b1, 32'd7, 32'h1111, 1'b0, lat, rd, st);
    @(negedge clk);
    ctrl[0]  = 32'h3;
    addr[0]  = 32'd7;
    wdata[0] = 32'h2222;
    @(posedge clk);
    #1;
    chk("rstseq_busy", stat[0], 32'h1);
    @(negedge clk);
    rst_n[0] = 1'b0;
    #1;
    chk("rstseq_stat", stat[0], 0);
    chk("rstseq_rdata", rdata[0], 0);
    ctrl[0] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n[0] = 1'b1;
    txn(0, 1'b0, 32'd7, 32'h0, 1'b0, lat, rd, st);
    chk("rstseq_rd7", rd, 32'h1111);
    chk("rstseq_lat", W'(lat), 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
